// File: rtl/l2_arb_pkg.sv
// ----------------------------------------------------------------------------
// l2_arb_pkg
// Shared definitions for the L2 bank arbiter:
//   - arb_state_e   : arbiter FSM state encoding (IDLE -> ISSUE -> WAIT)
//   - DEF_NUM_REQ   : default number of requesters sharing one bank
//   - DEF_TIMEOUT   : default WAIT cycles before an error response
//   - rr_wrap()     : (base + off) mod n for operands already below n,
//                     done with one compare/subtract instead of a divider
// ----------------------------------------------------------------------------
package l2_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_TIMEOUT = 15;

    // base and off are both < n, so the sum is < 2n and a single
    // conditional subtract gives the modulo result.
    function automatic int unsigned rr_wrap(input int unsigned base,
                                            input int unsigned off,
                                            input int unsigned n);
        int unsigned s;
        s = base + off;
        if (s >= n) begin
            s = s - n;
        end
        return s;
    endfunction

endpackage

// File: rtl/l2_bank_arb_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin selector. The search for a set request bit
// starts at rr_ptr and wraps modulo NUM_REQ; the first hit wins.
//
// Ports:
//   req     in  [NUM_REQ-1:0]  request vector
//   rr_ptr  in  [IDX_W-1:0]    index with highest priority this cycle
//   grant   out [NUM_REQ-1:0]  one-hot winner (all zero when no request)
//   idx     out [IDX_W-1:0]    binary index of the winner (0 when none)
//   any     out                at least one request present
// ----------------------------------------------------------------------------
module rr_arbiter
    import l2_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    // Candidate gi is the requester examined at search offset gi from rr_ptr.
    logic [IDX_W-1:0]   w_cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] w_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign w_cand_idx[gi] = IDX_W'(rr_wrap(32'(rr_ptr), 32'(gi), 32'(NUM_REQ)));
            assign w_hit[gi]      = req[w_cand_idx[gi]];
        end
    endgenerate

    // Lowest search offset with a hit wins; scanning downward lets the
    // last assignment be the highest-priority candidate.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                idx = w_cand_idx[k];
                any = 1'b1;
            end
        end
    end

    always_comb begin
        grant = '0;
        if (any) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/l2_bank_arb.sv
// ----------------------------------------------------------------------------
// l2_bank_arb
// Shares one L2 bank between NUM_REQ requesters with exactly one request in
// flight. A round-robin winner is accepted in IDLE, its command is captured
// and presented to the bank for one cycle (ISSUE), then the arbiter waits for
// bank_ready (WAIT) and returns a one-cycle response pulse to the owner.
// If the bank stays silent for TIMEOUT WAIT cycles an error response is sent.
// Nominal cadence: accept T, bank_en T+1, bank_ready T+2, rsp_valid T+3.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   req_valid/req_ready [N]      per-requester handshake (ready is one-hot)
//   req_wr [N]                   1 = write, 0 = read
//   req_addr [N][ADDR_WIDTH]     per-requester address
//   req_wdata [N][DATA_WIDTH]    per-requester write data
//   rsp_valid [N]                completion pulse to the owning requester
//   rsp_rdata [DATA_WIDTH]       read data (held across write completions)
//   rsp_err                      timeout flag, qualified by rsp_valid
//   bank_en/wr/addr/wdata        bank command, valid for one cycle
//   bank_rdata, bank_ready       bank result, ready one cycle after bank_en
// ----------------------------------------------------------------------------
module l2_bank_arb
    import l2_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int ADDR_WIDTH = 40,
    parameter int DATA_WIDTH = 64,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ-1:0]                  req_wr,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]                  rsp_valid,
    output logic [DATA_WIDTH-1:0]               rsp_rdata,
    output logic                                rsp_err,
    output logic                                bank_en,
    output logic                                bank_wr,
    output logic [ADDR_WIDTH-1:0]               bank_addr,
    output logic [DATA_WIDTH-1:0]               bank_wdata,
    input  logic [DATA_WIDTH-1:0]               bank_rdata,
    input  logic                                bank_ready
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // Wait counter is at least 4 bits wide, wider only if TIMEOUT needs it.
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
    // Counter value in the last WAIT cycle before the error response.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_e              r_state;
    logic [IDX_W-1:0]        r_rr_ptr;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_wr;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [IDX_W-1:0]        r_id;
    logic                    r_bank_en;
    logic [NUM_REQ-1:0]      r_rsp_valid;
    logic                    r_rsp_err;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;

    logic [NUM_REQ-1:0]      w_grant;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_any;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req    (req_valid),
        .rr_ptr (r_rr_ptr),
        .grant  (w_grant),
        .idx    (w_idx),
        .any    (w_any)
    );

    // The grant is only offered in IDLE; rst_n is folded in so nothing is
    // accepted while reset is held, even though state already reads IDLE.
    assign req_ready  = (rst_n && (r_state == ST_IDLE)) ? w_grant : '0;

    assign bank_en    = r_bank_en;
    assign bank_wr    = r_wr;
    assign bank_addr  = r_addr;
    assign bank_wdata = r_wdata;

    assign rsp_valid  = r_rsp_valid;
    assign rsp_err    = r_rsp_err;
    assign rsp_rdata  = r_rsp_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_cnt       <= '0;
            r_wr        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_id        <= '0;
            r_bank_en   <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            // Pulse-type outputs default low every cycle.
            r_rsp_valid <= '0;
            r_rsp_err   <= 1'b0;
            r_bank_en   <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_wr      <= req_wr[w_idx];
                        r_addr    <= req_addr[w_idx];
                        r_wdata   <= req_wdata[w_idx];
                        r_id      <= w_idx;
                        r_rr_ptr  <= IDX_W'(rr_wrap(32'(w_idx), 32'd1, 32'(NUM_REQ)));
                        // Registered so bank_en is high for exactly the ISSUE cycle.
                        r_bank_en <= 1'b1;
                        r_state   <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (bank_ready) begin
                        r_rsp_valid[r_id] <= 1'b1;
                        // Write completions leave the last read data visible.
                        if (!r_wr) begin
                            r_rsp_rdata <= bank_rdata;
                        end
                        r_state <= ST_IDLE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_rsp_valid[r_id] <= 1'b1;
                        r_rsp_err         <= 1'b1;
                        r_state           <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/l2_bank_arb.md
L2_BANK_ARB -- requirements
Module: l2_bank_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing one L2 bank.
REQ-002 SHALL have parameter ADDR_WIDTH, default 40: request/bank address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 64: write/read data width.
REQ-004 SHALL have parameter TIMEOUT, default 15: maximum WAIT cycles before an error response.
REQ-005 SHALL have port clk  input  1: sole clock; all state on posedge clk.
REQ-006 SHALL have port rst_n  input  1: asynchronous active-low reset.
REQ-007 SHALL have port req_valid  input  NUM_REQ: per-requester request valid.
REQ-008 SHALL have port req_ready  output  NUM_REQ: per-requester accept, at most one bit set.
REQ-009 SHALL have port req_wr  input  NUM_REQ: 1 = write, 0 = read.
REQ-010 SHALL have port req_addr  input  NUM_REQ x ADDR_WIDTH: per-requester address.
REQ-011 SHALL have port req_wdata  input  NUM_REQ x DATA_WIDTH: per-requester write data.
REQ-012 SHALL have port rsp_valid  output  NUM_REQ: one-cycle completion pulse to the owning requester.
REQ-013 SHALL have port rsp_rdata  output  DATA_WIDTH: read data, shared, valid with rsp_valid.
REQ-014 SHALL have port rsp_err  output  1: timeout flag, valid with rsp_valid.
REQ-015 SHALL have ports bank_en, bank_wr (output 1), bank_addr (output ADDR_WIDTH), bank_wdata (output DATA_WIDTH): bank command.
REQ-016 SHALL have ports bank_rdata (input DATA_WIDTH), bank_ready (input 1): bank result; bank returns ready one cycle after en.

Function
REQ-017 SHALL implement FSM IDLE -> ISSUE -> WAIT -> IDLE; exactly one request in flight.
REQ-018 In IDLE with any req_valid, SHALL assert req_ready for the round-robin winner combinationally, capture its wr/addr/wdata/id into registers, and go to ISSUE.
REQ-019 Round-robin: search starts at rr_ptr, wraps modulo NUM_REQ; after a grant to i, rr_ptr <= (i+1) mod NUM_REQ.
REQ-020 req_ready SHALL be 0 in ISSUE and WAIT regardless of req_valid.
REQ-021 In ISSUE, SHALL drive bank_en=1 for exactly one cycle with captured wr/addr/wdata, then go to WAIT; bank_en=0 in all other states.
REQ-022 In WAIT, on bank_ready=1 SHALL register rsp_valid[id]=1, rsp_rdata=bank_rdata (reads only; writes hold previous rsp_rdata), rsp_err=0, and go to IDLE.
REQ-023 In WAIT, a 4-bit-minimum counter SHALL count cycles; on reaching TIMEOUT without bank_ready, SHALL pulse rsp_valid[id] with rsp_err=1 and return to IDLE.
REQ-024 Latency: accept at cycle T, bank_en at T+1, bank_ready expected T+2, rsp_valid at T+3; a new accept MAY occur at T+3 (throughput 1 per 3 cycles).
REQ-025 rsp_valid SHALL be a single-cycle pulse; rsp_err SHALL be 0 whenever rsp_valid is all-zero.
REQ-026 bank_ready asserted outside WAIT SHALL be ignored.
REQ-027 A requester dropping req_valid before grant SHALL lose nothing; no request is stored until req_ready.

Reset
REQ-028 On rst_n=0, asynchronously: state=IDLE, rr_ptr=0, counter=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, captured registers=0; bank_en=0 and req_ready=0 during reset.
REQ-029 Reset mid-operation SHALL drop the in-flight request with no response.

Structure
REQ-030 Package l2_arb_pkg SHALL hold the FSM state enum and default NUM_REQ/TIMEOUT constants.
REQ-031 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req vector, rr_ptr; outputs one-hot grant, index, any).

Verification
REQ-032 Single read: req_valid[2]=1, addr=0x40 after bank written 0xDEAD -> req_ready[2] at T, bank_en at T+1, rsp_valid[2] with rsp_rdata=0xDEAD at T+3.
REQ-033 All four requesters valid continuously from reset -> grants in order 0,1,2,3,0, one per 3 cycles.
REQ-034 rr_ptr=3, requesters 1 and 3 valid -> 3 granted first, then 1 (wrap-around).
REQ-035 bank_ready held 0 -> rsp_valid with rsp_err=1 exactly TIMEOUT cycles after entering WAIT.
REQ-036 rst_n pulsed low during WAIT -> no rsp_valid, next grant goes to requester 0.
